// File: rtl/mod_counter_chain.sv
// mod_counter_chain
//   Cascaded modulo counter built from DIGITS digit stages of WIDTH bits.
//   Digits 0..DIGITS-2 count modulo BASE and the top digit counts modulo
//   TOP_MOD (defaults give 00..59). Supports up/down counting, enable,
//   synchronous load with out-of-range digit sanitising, and a
//   combinational terminal-count carry for cascading further chains.
//
// Ports
//   sysClk     in   system clock, all state changes on the rising edge
//   sysRst     in   synchronous active-high reset (count = 0, loadErr = 0)
//   en         in   count enable
//   up         in   1 = increment, 0 = decrement
//   load       in   synchronous load request (has priority over en)
//   loadValue  in   digit-packed load value, digit i at [i*WIDTH +: WIDTH]
//   count      out  current count, same packing as loadValue
//   carryOut   out  high in the cycle whose next edge wraps the whole chain
//   loadErr    out  registered: the last load had an out-of-range digit
module mod_counter_chain #(
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 2,
    parameter int BASE    = 10,
    parameter int TOP_MOD = 6
) (
    input  logic                      sysClk,
    input  logic                      sysRst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGITS*WIDTH-1:0]   loadValue,
    output logic [DIGITS*WIDTH-1:0]   count,
    output logic                      carryOut,
    output logic                      loadErr
);

    localparam int NW = DIGITS * WIDTH;

    logic [NW-1:0] count_q, count_d;
    logic [NW-1:0] step_val;
    logic [NW-1:0] load_val;
    logic          loadErr_q, loadErr_d;
    logic          load_bad;
    logic          chain_term;

    function automatic int digit_mod(input int idx);
        return (idx == DIGITS - 1) ? TOP_MOD : BASE;
    endfunction

    // Ripple the step condition from digit 0 upward: a digit steps only when
    // every lower digit sits at its wrap point for the current direction.
    // The ripple leaving the top digit means the whole chain is terminal.
    always_comb begin : step_logic
        logic [WIDTH-1:0] dig;
        logic [WIDTH-1:0] dmax;
        logic             ripple;
        step_val = count_q;
        ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig  = count_q[i*WIDTH +: WIDTH];
            dmax = WIDTH'(digit_mod(i) - 1);
            if (ripple) begin
                if (up) begin
                    step_val[i*WIDTH +: WIDTH] = (dig == dmax) ? '0 : dig + WIDTH'(1);
                end else begin
                    step_val[i*WIDTH +: WIDTH] = (dig == '0) ? dmax : dig - WIDTH'(1);
                end
            end
            ripple = ripple & (up ? (dig == dmax) : (dig == '0));
        end
        chain_term = ripple;
    end

    // Any digit at or above its modulus is replaced by zero so the counter
    // never holds an unreachable value.
    always_comb begin : load_logic
        logic [WIDTH-1:0] dig;
        load_val = loadValue;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = loadValue[i*WIDTH +: WIDTH];
            if (int'(dig) >= digit_mod(i)) begin
                load_val[i*WIDTH +: WIDTH] = '0;
                load_bad = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        count_d   = count_q;
        loadErr_d = loadErr_q;
        if (load) begin
            count_d   = load_val;
            loadErr_d = load_bad;
        end else if (en) begin
            count_d = step_val;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            count_q   <= '0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign count    = count_q;
    assign loadErr  = loadErr_q;
    assign carryOut = en & ~load & ~sysRst & chain_term;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Bench for mod_counter_chain: a default 00..59 chain (A) and a
// three-digit 000..199 chain (B). Each chain is tracked by an integer
// model of the count value; directed steps pin the model with literals.
module tb_mod_counter_chain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, enA, upA, loadA;
    logic [7:0]  lvA, countA;
    logic        carryA, errA;

    logic        rstB, enB, upB, loadB;
    logic [11:0] lvB, countB;
    logic        carryB, errB;

    mod_counter_chain dutA (
        .sysClk(clk), .sysRst(rstA), .en(enA), .up(upA), .load(loadA),
        .loadValue(lvA), .count(countA), .carryOut(carryA), .loadErr(errA)
    );

    mod_counter_chain #(.WIDTH(4), .DIGITS(3), .BASE(10), .TOP_MOD(2)) dutB (
        .sysClk(clk), .sysRst(rstB), .en(enB), .up(upB), .load(loadB),
        .loadValue(lvB), .count(countB), .carryOut(carryB), .loadErr(errB)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int modOf(input int i, input int d, input int b, input int t);
        return (i == d - 1) ? t : b;
    endfunction

    // Integer value -> digit-packed BCD-like word.
    function automatic logic [31:0] pack(input int v, input int d, input int b, input int t);
        logic [31:0] r = '0;
        int          x = v;
        for (int i = 0; i < d; i++) begin
            r = r | (32'(x % modOf(i, d, b, t)) << (4 * i));
            x = x / modOf(i, d, b, t);
        end
        return r;
    endfunction

    function automatic int loadVal(input logic [31:0] lv, input int d, input int b, input int t);
        int v = 0;
        int w = 1;
        int dg;
        for (int i = 0; i < d; i++) begin
            dg = int'((lv >> (4 * i)) & 32'hF);
            if (dg >= modOf(i, d, b, t)) dg = 0;
            v = v + dg * w;
            w = w * modOf(i, d, b, t);
        end
        return v;
    endfunction

    function automatic bit loadBad(input logic [31:0] lv, input int d, input int b, input int t);
        bit bad = 1'b0;
        for (int i = 0; i < d; i++)
            if (int'((lv >> (4 * i)) & 32'hF) >= modOf(i, d, b, t)) bad = 1'b1;
        return bad;
    endfunction

    localparam int MA = 60;
    localparam int MB = 200;
    int mA = 0, mB = 0;
    bit eA = 1'b0, eB = 1'b0;

    always @(posedge clk) begin
        if (rstA) begin
            mA <= 0; eA <= 1'b0;
        end else if (loadA) begin
            mA <= loadVal(32'(lvA), 2, 10, 6); eA <= loadBad(32'(lvA), 2, 10, 6);
        end else if (enA) begin
            mA <= upA ? (mA + 1) % MA : (mA + MA - 1) % MA;
        end
        if (rstB) begin
            mB <= 0; eB <= 1'b0;
        end else if (loadB) begin
            mB <= loadVal(32'(lvB), 3, 10, 2); eB <= loadBad(32'(lvB), 3, 10, 2);
        end else if (enB) begin
            mB <= upB ? (mB + 1) % MB : (mB + MB - 1) % MB;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_countA", 32'(countA), pack(mA, 2, 10, 6));
            chk("model_errA", 32'(errA), 32'(eA));
            chk("model_carryA", 32'(carryA),
                32'(enA & ~loadA & ~rstA & (upA ? (mA == MA - 1) : (mA == 0))));
            chk("model_countB", 32'(countB), pack(mB, 3, 10, 2));
            chk("model_errB", 32'(errB), 32'(eB));
            chk("model_carryB", 32'(carryB),
                32'(enB & ~loadB & ~rstB & (upB ? (mB == MB - 1) : (mB == 0))));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstA = 1'b1; enA = 1'b0; upA = 1'b1; loadA = 1'b0; lvA = '0;
        rstB = 1'b1; enB = 1'b0; upB = 1'b1; loadB = 1'b0; lvB = '0;
        cyc();
        rstA = 1'b0; rstB = 1'b0;
        armed = 1'b1;
        #1;
        chk("rst_countA", 32'(countA), 32'h00);
        chk("rst_errA", 32'(errA), 32'h0);
        chk("rst_countB", 32'(countB), 32'h000);

        // Up count through the full 00..59 range
        enA = 1'b1; upA = 1'b1;
        repeat (59) cyc();
        chk("up59_count", 32'(countA), 32'h59);
        chk("up59_carry", 32'(carryA), 32'h1);
        cyc();
        chk("wrap_count", 32'(countA), 32'h00);
        chk("wrap_carry", 32'(carryA), 32'h0);

        // Down count from reset
        rstA = 1'b1; cyc(); rstA = 1'b0; upA = 1'b0; #1;
        chk("dn0_carry", 32'(carryA), 32'h1);
        cyc(); chk("dn_59", 32'(countA), 32'h59);
        cyc(); chk("dn_58", 32'(countA), 32'h58);
        repeat (8) cyc(); chk("dn_50", 32'(countA), 32'h50);
        cyc(); chk("dn_49", 32'(countA), 32'h49);

        // Loads and load validation
        loadA = 1'b1; lvA = 8'h37; cyc(); loadA = 1'b0; enA = 1'b0; #1;
        chk("ld37_count", 32'(countA), 32'h37);
        chk("ld37_err", 32'(errA), 32'h0);
        loadA = 1'b1; lvA = 8'h7A; cyc(); loadA = 1'b0; enA = 1'b1; upA = 1'b1; #1;
        chk("ld7A_count", 32'(countA), 32'h00);
        chk("ld7A_err", 32'(errA), 32'h1);
        repeat (5) cyc();
        chk("hold_err", 32'(errA), 32'h1);
        chk("hold_count", 32'(countA), 32'h05);
        loadA = 1'b1; lvA = 8'h12; cyc(); loadA = 1'b0; enA = 1'b0; #1;
        chk("ld12_count", 32'(countA), 32'h12);
        chk("ld12_err", 32'(errA), 32'h0);
        loadA = 1'b1; lvA = 8'h65; cyc(); loadA = 1'b0; #1;
        chk("ld65_count", 32'(countA), 32'h05);
        chk("ld65_err", 32'(errA), 32'h1);

        // Load beats enable; load masks carry
        loadA = 1'b1; lvA = 8'h59; cyc();
        lvA = 8'h20; enA = 1'b1; upA = 1'b1; #1;
        chk("ld_carry_mask", 32'(carryA), 32'h0);
        cyc(); loadA = 1'b0; enA = 1'b0; #1;
        chk("ld_en_count", 32'(countA), 32'h20);

        // Reset beats load
        loadA = 1'b1; lvA = 8'h7A; cyc(); #1;
        chk("pre_rst_err", 32'(errA), 32'h1);
        rstA = 1'b1; lvA = 8'h37; enA = 1'b1; upA = 1'b0; #1;
        chk("rst_carry_mask", 32'(carryA), 32'h0);
        cyc(); rstA = 1'b0; loadA = 1'b0; enA = 1'b0; #1;
        chk("rstld_count", 32'(countA), 32'h00);
        chk("rstld_err", 32'(errA), 32'h0);

        // Direction change and hold around 09/10
        loadA = 1'b1; lvA = 8'h09; cyc(); loadA = 1'b0; enA = 1'b1; upA = 1'b1;
        cyc(); chk("dir_10", 32'(countA), 32'h10);
        upA = 1'b0; cyc(); chk("dir_09", 32'(countA), 32'h09);
        enA = 1'b0; repeat (4) cyc(); #1;
        chk("hold_09", 32'(countA), 32'h09);
        chk("hold_carry", 32'(carryA), 32'h0);

        // Reset mid-count
        loadA = 1'b1; lvA = 8'h44; cyc(); loadA = 1'b0; enA = 1'b1; upA = 1'b1;
        cyc(); chk("mid_45", 32'(countA), 32'h45);
        rstA = 1'b1; cyc(); rstA = 1'b0;
        chk("mid_rst", 32'(countA), 32'h00);
        cyc(); chk("mid_resume", 32'(countA), 32'h01);
        enA = 1'b0;

        // Three-digit chain 000..199
        loadB = 1'b1; lvB = 12'h198; cyc(); loadB = 1'b0; enB = 1'b1; upB = 1'b1;
        cyc(); #1;
        chk("B_199", 32'(countB), 32'h199);
        chk("B_carry199", 32'(carryB), 32'h1);
        cyc(); #1;
        chk("B_000", 32'(countB), 32'h000);
        chk("B_carry000", 32'(carryB), 32'h0);
        upB = 1'b0; #1;
        chk("B_dncarry", 32'(carryB), 32'h1);
        cyc(); chk("B_dn199", 32'(countB), 32'h199);
        loadB = 1'b1; lvB = 12'h2A5; cyc(); loadB = 1'b0; enB = 1'b0; #1;
        chk("B_ld_count", 32'(countB), 32'h005);
        chk("B_ld_err", 32'(errB), 32'h1);
        cyc();

        @(posedge clk);
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
